// File: rtl/eth_rx_cmd_decoder_if.sv
// Byte-wide AXI-stream link from the MAC rx FIFO into the command decoder.
interface eth_rx_cmd_decoder_if;
  logic [7:0] rx_axis_fifo_tdata;
  logic       rx_axis_fifo_tvalid;
  logic       rx_axis_fifo_tlast;
  logic       rx_axis_fifo_tready;

  modport master (
    output rx_axis_fifo_tdata, rx_axis_fifo_tvalid, rx_axis_fifo_tlast,
    input  rx_axis_fifo_tready
  );

  modport slave (
    input  rx_axis_fifo_tdata, rx_axis_fifo_tvalid, rx_axis_fifo_tlast,
    output rx_axis_fifo_tready
  );
endinterface

// File: rtl/eth_rx_cmd_decoder.sv
// Decodes run-control command frames from the MAC rx byte stream into registers.
// Defining ETH_RX_CMD_READBACK_EN adds the read opcode and the rb_valid/rb_data outputs.
module eth_rx_cmd_decoder #(
  parameter logic [47:0] LOCAL_MAC     = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] CMD_ETHERTYPE = 16'h88B5,
  parameter logic [11:0] CNT_TH_DEF    = 12'd256,
  parameter logic [15:0] IDLE_TH_DEF   = 16'd1000
) (
  input  logic                       clk,
  input  logic                       reset,
  eth_rx_cmd_decoder_if.slave        rx,
  output logic                       soft_reset,
  output logic                       tds_mode,
  output logic                       debug_enable,
  output logic [3:0]                 enable,
  output logic [11:0]                counter_th,
  output logic [15:0]                idle_counter_number_th,
  output logic [47:0]                D_MAC_add,
  output logic [47:0]                S_MAC_add,
  output logic                       cmd_strobe,
  output logic [15:0]                good_frame_count,
`ifdef ETH_RX_CMD_READBACK_EN
  output logic                       rb_valid,
  output logic [31:0]                rb_data,
`endif
  output logic [15:0]                bad_frame_count
);

  typedef enum logic [2:0] {ST_HDR, ST_CMD, ST_DATA, ST_WAIT_LAST, ST_DROP} state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        locOk_q, locOk_d, bcOk_q, bcOk_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        beat, opLegal, isRead, commit, dropEnd;
  logic [7:0]  locByte, typeByte;
  logic [31:0] wrData;

  logic        softReset_q, tdsMode_q, debugEn_q, cmdStrobe_q;
  logic [3:0]  enable_q;
  logic [11:0] counterTh_q;
  logic [15:0] idleTh_q, goodCnt_q, badCnt_q;
  logic [47:0] dMac_q, sMac_q;

  assign rx.rx_axis_fifo_tready = ~reset;
  assign beat = rx.rx_axis_fifo_tvalid & ~reset;

`ifdef ETH_RX_CMD_READBACK_EN
  logic opRead_q, opRead_d;
  assign opLegal = (rx.rx_axis_fifo_tdata == 8'h01) || (rx.rx_axis_fifo_tdata == 8'h02);
  assign isRead  = opRead_q;
`else
  assign opLegal = (rx.rx_axis_fifo_tdata == 8'h01);
  assign isRead  = 1'b0;
`endif

  always_comb begin
    locByte = 8'h00;
    case (idx_q)
      5'd0:    locByte = LOCAL_MAC[47:40];
      5'd1:    locByte = LOCAL_MAC[39:32];
      5'd2:    locByte = LOCAL_MAC[31:24];
      5'd3:    locByte = LOCAL_MAC[23:16];
      5'd4:    locByte = LOCAL_MAC[15:8];
      5'd5:    locByte = LOCAL_MAC[7:0];
      default: locByte = 8'h00;
    endcase
  end

  assign typeByte = (idx_q == 5'd12) ? CMD_ETHERTYPE[15:8] : CMD_ETHERTYPE[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HDR;
      idx_q   <= '0;
      locOk_q <= 1'b1;
      bcOk_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef ETH_RX_CMD_READBACK_EN
      opRead_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      locOk_q <= locOk_d;
      bcOk_q  <= bcOk_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef ETH_RX_CMD_READBACK_EN
      opRead_q <= opRead_d;
`endif
    end
  end

  // Local and broadcast DMAC are tracked separately; the frame drops only once both fail.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    locOk_d = locOk_q;
    bcOk_d  = bcOk_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef ETH_RX_CMD_READBACK_EN
    opRead_d = opRead_q;
`endif
    if (beat) begin
      idx_d = (idx_q == 5'd20) ? idx_q : idx_q + 5'd1;
      case (state_q)
        ST_HDR: begin
          if (idx_q < 5'd6) begin
            locOk_d = locOk_q & (rx.rx_axis_fifo_tdata == locByte);
            bcOk_d  = bcOk_q & (rx.rx_axis_fifo_tdata == 8'hFF);
            if (!locOk_d && !bcOk_d) state_d = ST_DROP;
          end else if (idx_q >= 5'd12) begin
            if (rx.rx_axis_fifo_tdata != typeByte) state_d = ST_DROP;
            else if (idx_q == 5'd13)               state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          if (idx_q == 5'd14) begin
            if (!opLegal) state_d = ST_DROP;
`ifdef ETH_RX_CMD_READBACK_EN
            opRead_d = (rx.rx_axis_fifo_tdata == 8'h02);
`endif
          end else begin
            addr_d = rx.rx_axis_fifo_tdata[2:0];
            if (rx.rx_axis_fifo_tdata > 8'd6) state_d = ST_DROP;
            else                               state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          data_d = {data_q[23:0], rx.rx_axis_fifo_tdata};
          if (idx_q == 5'd19) state_d = ST_WAIT_LAST;
        end
        default: ;
      endcase
      if (rx.rx_axis_fifo_tlast) begin
        state_d = ST_HDR;
        idx_d   = '0;
        locOk_d = 1'b1;
        bcOk_d  = 1'b1;
      end
    end
  end

  // Any frame end that is not a full command (runt, mismatch, drop) counts as bad.
  always_comb begin
    commit  = 1'b0;
    dropEnd = 1'b0;
    wrData  = (state_q == ST_DATA) ? {data_q[23:0], rx.rx_axis_fifo_tdata} : data_q;
    if (beat && rx.rx_axis_fifo_tlast) begin
      if (state_q == ST_WAIT_LAST || (state_q == ST_DATA && idx_q == 5'd19)) commit  = 1'b1;
      else                                                                   dropEnd = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      softReset_q <= 1'b0;
      tdsMode_q   <= 1'b1;
      debugEn_q   <= 1'b0;
      enable_q    <= 4'h0;
      counterTh_q <= CNT_TH_DEF;
      idleTh_q    <= IDLE_TH_DEF;
      dMac_q      <= 48'hFFFF_FFFF_FFFF;
      sMac_q      <= LOCAL_MAC;
      cmdStrobe_q <= 1'b0;
      goodCnt_q   <= '0;
      badCnt_q    <= '0;
    end else begin
      cmdStrobe_q <= 1'b0;
      if (commit && !isRead) begin
        cmdStrobe_q <= 1'b1;
        case (addr_q)
          3'd0: begin
            softReset_q <= wrData[0];
            tdsMode_q   <= wrData[1];
            debugEn_q   <= wrData[2];
            enable_q    <= wrData[7:4];
          end
          3'd1:    counterTh_q    <= wrData[11:0];
          3'd2:    idleTh_q       <= wrData[15:0];
          3'd3:    dMac_q[47:32]  <= wrData[15:0];
          3'd4:    dMac_q[31:0]   <= wrData;
          3'd5:    sMac_q[47:32]  <= wrData[15:0];
          3'd6:    sMac_q[31:0]   <= wrData;
          default: ;
        endcase
      end
      if (commit && goodCnt_q != 16'hFFFF)  goodCnt_q <= goodCnt_q + 16'd1;
      if (dropEnd && badCnt_q != 16'hFFFF)  badCnt_q  <= badCnt_q + 16'd1;
    end
  end

`ifdef ETH_RX_CMD_READBACK_EN
  logic        rbValid_q;
  logic [31:0] rbData_q, rbMux;

  always_comb begin
    rbMux = '0;
    case (addr_q)
      3'd0:    rbMux = {24'd0, enable_q, 1'b0, debugEn_q, tdsMode_q, softReset_q};
      3'd1:    rbMux = {20'd0, counterTh_q};
      3'd2:    rbMux = {16'd0, idleTh_q};
      3'd3:    rbMux = {16'd0, dMac_q[47:32]};
      3'd4:    rbMux = dMac_q[31:0];
      3'd5:    rbMux = {16'd0, sMac_q[47:32]};
      3'd6:    rbMux = sMac_q[31:0];
      default: rbMux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbValid_q <= 1'b0;
      rbData_q  <= '0;
    end else begin
      rbValid_q <= commit & isRead;
      if (commit && isRead) rbData_q <= rbMux;
    end
  end

  assign rb_valid = rbValid_q;
  assign rb_data  = rbData_q;
`endif

  assign soft_reset             = softReset_q;
  assign tds_mode               = tdsMode_q;
  assign debug_enable           = debugEn_q;
  assign enable                 = enable_q;
  assign counter_th             = counterTh_q;
  assign idle_counter_number_th = idleTh_q;
  assign D_MAC_add              = dMac_q;
  assign S_MAC_add              = sMac_q;
  assign cmd_strobe             = cmdStrobe_q;
  assign good_frame_count       = goodCnt_q;
  assign bad_frame_count        = badCnt_q;

endmodule

// File: tb/tb_eth_rx_cmd_decoder.sv
// Table-driven, hand-sequenced and randomized checks of eth_rx_cmd_decoder against a frame-level model.
module tb_eth_rx_cmd_decoder;

  localparam logic [47:0] LOCAL_MAC = 48'h00_0A_35_00_00_01;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  eth_rx_cmd_decoder_if rxIf();

  logic        softReset, tdsMode, debugEnable, cmdStrobe;
  logic [3:0]  enableOut;
  logic [11:0] counterTh;
  logic [15:0] idleTh, goodCount, badCount;
  logic [47:0] dMac, sMac;
`ifdef ETH_RX_CMD_READBACK_EN
  logic        rbValid;
  logic [31:0] rbData;
`endif

  eth_rx_cmd_decoder dut (
    .clk                    (clk),
    .reset                  (reset),
    .rx                     (rxIf),
    .soft_reset             (softReset),
    .tds_mode               (tdsMode),
    .debug_enable           (debugEnable),
    .enable                 (enableOut),
    .counter_th             (counterTh),
    .idle_counter_number_th (idleTh),
    .D_MAC_add              (dMac),
    .S_MAC_add              (sMac),
    .cmd_strobe             (cmdStrobe),
    .good_frame_count       (goodCount),
`ifdef ETH_RX_CMD_READBACK_EN
    .rb_valid               (rbValid),
    .rb_data                (rbData),
`endif
    .bad_frame_count        (badCount)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  frame[$];
  logic [31:0] mRegs[7];
  logic [15:0] mGood, mBad;
  logic        mStrobe;

  typedef struct {
    logic [47:0] dmac;
    logic [15:0] etype;
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    int          len;
    logic        expStrobe;
    logic [15:0] expGood;
    logic [15:0] expBad;
  } vec_t;

  vec_t vecs[13];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mRegs[0] = 32'h0000_0002;
    mRegs[1] = 32'd256;
    mRegs[2] = 32'd1000;
    mRegs[3] = 32'h0000_FFFF;
    mRegs[4] = 32'hFFFF_FFFF;
    mRegs[5] = {16'd0, LOCAL_MAC[47:32]};
    mRegs[6] = LOCAL_MAC[31:0];
    mGood    = '0;
    mBad     = '0;
    mStrobe  = 1'b0;
  endtask

  // Classifies a whole frame by the command rules and applies its effect to the model.
  task automatic modelFrame();
    logic [47:0] lm;
    logic        isLoc, isBc, ok;
    logic [7:0]  op, addr;
    logic [31:0] data;
    bit          isRead;
    lm      = LOCAL_MAC;
    mStrobe = 1'b0;
    isRead  = 1'b0;
    addr    = 8'd0;
    data    = 32'd0;
    ok      = (frame.size() >= 20);
    if (ok) begin
      isLoc = 1'b1;
      isBc  = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (frame[i] != lm[47-8*i -: 8]) isLoc = 1'b0;
        if (frame[i] != 8'hFF)           isBc  = 1'b0;
      end
      op   = frame[14];
      addr = frame[15];
      data = {frame[16], frame[17], frame[18], frame[19]};
`ifdef ETH_RX_CMD_READBACK_EN
      isRead = (op == 8'h02);
`endif
      ok = (isLoc || isBc) && ({frame[12], frame[13]} == 16'h88B5) &&
           (op == 8'h01 || isRead) && (addr <= 8'd6);
    end
    if (!ok) begin
      if (mBad != 16'hFFFF) mBad = mBad + 16'd1;
    end else begin
      if (mGood != 16'hFFFF) mGood = mGood + 16'd1;
      if (!isRead) begin
        mRegs[addr[2:0]] = data;
        mStrobe = 1'b1;
      end
    end
  endtask

  task automatic buildFrame(input logic [47:0] dmac, input logic [15:0] etype, input logic [7:0] op,
                            input logic [7:0] addr, input logic [31:0] data, input int len,
                            input bit padRand);
    logic [47:0] smac;
    smac = 48'h02_11_22_33_44_55;
    frame.delete();
    for (int i = 5; i >= 0; i--) frame.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frame.push_back(smac[8*i +: 8]);
    frame.push_back(etype[15:8]);
    frame.push_back(etype[7:0]);
    frame.push_back(op);
    frame.push_back(addr);
    for (int i = 3; i >= 0; i--) frame.push_back(data[8*i +: 8]);
    while (frame.size() < len) frame.push_back(padRand ? 8'($urandom) : 8'h00);
    while (frame.size() > len) void'(frame.pop_back());
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    @(negedge clk);
    rxIf.rx_axis_fifo_tvalid = 1'b1;
    rxIf.rx_axis_fifo_tdata  = b;
    rxIf.rx_axis_fifo_tlast  = last;
    @(posedge clk);
  endtask

  task automatic applyStimulus(input int gapMax);
    int g;
    for (int i = 0; i < frame.size(); i++) begin
      g = (gapMax > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, gapMax)) : 0;
      repeat (g) begin
        @(negedge clk);
        rxIf.rx_axis_fifo_tvalid = 1'b0;
        rxIf.rx_axis_fifo_tlast  = 1'b0;
      end
      sendByte(frame[i], i == frame.size() - 1);
    end
    @(negedge clk);
    rxIf.rx_axis_fifo_tvalid = 1'b0;
    rxIf.rx_axis_fifo_tlast  = 1'b0;
    modelFrame();
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, " tready"},       64'(rxIf.rx_axis_fifo_tready), 64'(!reset));
    cmp({tag, " soft_reset"},   64'(softReset),   64'(mRegs[0][0]));
    cmp({tag, " tds_mode"},     64'(tdsMode),     64'(mRegs[0][1]));
    cmp({tag, " debug_enable"}, 64'(debugEnable), 64'(mRegs[0][2]));
    cmp({tag, " enable"},       64'(enableOut),   64'(mRegs[0][7:4]));
    cmp({tag, " counter_th"},   64'(counterTh),   64'(mRegs[1][11:0]));
    cmp({tag, " idle_th"},      64'(idleTh),      64'(mRegs[2][15:0]));
    cmp({tag, " D_MAC"},        64'(dMac),        64'({mRegs[3][15:0], mRegs[4]}));
    cmp({tag, " S_MAC"},        64'(sMac),        64'({mRegs[5][15:0], mRegs[6]}));
    cmp({tag, " cmd_strobe"},   64'(cmdStrobe),   64'(mStrobe));
    cmp({tag, " good_count"},   64'(goodCount),   64'(mGood));
    cmp({tag, " bad_count"},    64'(badCount),    64'(mBad));
  endtask

  initial begin
    logic [63:0] rnd64;
    logic [47:0] dmac;
    logic [15:0] etype;
    logic [7:0]  op;
    int          r, len;

    rxIf.rx_axis_fifo_tvalid = 1'b0;
    rxIf.rx_axis_fifo_tdata  = 8'h00;
    rxIf.rx_axis_fifo_tlast  = 1'b0;
    #2 reset = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset idle");

    vecs[0]  = '{LOCAL_MAC,            16'h88B5, 8'h01, 8'h00, 32'h0000_00F6, 20, 1'b1, 16'd1, 16'd0};
    vecs[1]  = '{BCAST,                16'h88B5, 8'h01, 8'h04, 32'h1122_3344, 60, 1'b1, 16'd2, 16'd0};
    vecs[2]  = '{BCAST,                16'h88B5, 8'h01, 8'h03, 32'h0000_AABB, 60, 1'b1, 16'd3, 16'd0};
    vecs[3]  = '{LOCAL_MAC,            16'h0800, 8'h01, 8'h00, 32'h0000_0001, 20, 1'b0, 16'd3, 16'd1};
    vecs[4]  = '{LOCAL_MAC,            16'h88B5, 8'h01, 8'h07, 32'h0000_0001, 20, 1'b0, 16'd3, 16'd2};
    vecs[5]  = '{LOCAL_MAC,            16'h88B5, 8'h01, 8'h01, 32'h0000_0123, 18, 1'b0, 16'd3, 16'd3};
    vecs[6]  = '{LOCAL_MAC,            16'h88B5, 8'h01, 8'h01, 32'h0000_00FF, 20, 1'b1, 16'd4, 16'd3};
    vecs[7]  = '{LOCAL_MAC,            16'h88B5, 8'h03, 8'h01, 32'h0000_0456, 20, 1'b0, 16'd4, 16'd4};
    vecs[8]  = '{48'h00_0A_35_00_00_02, 16'h88B5, 8'h01, 8'h01, 32'h0000_0789, 20, 1'b0, 16'd4, 16'd5};
    vecs[9]  = '{48'h00_0A_35_FF_FF_FF, 16'h88B5, 8'h01, 8'h01, 32'h0000_0ABC, 20, 1'b0, 16'd4, 16'd6};
    vecs[10] = '{LOCAL_MAC,            16'h88B5, 8'h01, 8'h06, 32'h1234_5678, 64, 1'b1, 16'd5, 16'd6};
    vecs[11] = '{LOCAL_MAC,            16'h88B5, 8'h01, 8'h05, 32'hFFFF_0102, 20, 1'b1, 16'd6, 16'd6};
    vecs[12] = '{LOCAL_MAC,            16'h88B5, 8'h01, 8'h02, 32'hABCD_1234, 21, 1'b1, 16'd7, 16'd6};

    for (int v = 0; v < 13; v++) begin
      buildFrame(vecs[v].dmac, vecs[v].etype, vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].len, 1'b0);
      applyStimulus(0);
      checkOutput($sformatf("vec%0d", v));
      cmp($sformatf("vec%0d table strobe", v), 64'(cmdStrobe), 64'(vecs[v].expStrobe));
      cmp($sformatf("vec%0d table good", v),   64'(goodCount), 64'(vecs[v].expGood));
      cmp($sformatf("vec%0d table bad", v),    64'(badCount),  64'(vecs[v].expBad));
      if (v == 0) begin
        cmp("vec0 enable", 64'(enableOut), 64'(4'hF));
        cmp("vec0 debug",  64'(debugEnable), 64'(1'b1));
      end
      if (v == 2) cmp("vec2 D_MAC", 64'(dMac), 64'(48'hAABB_1122_3344));
      if (v == 6) cmp("vec6 counter_th", 64'(counterTh), 64'(12'h0FF));
      @(negedge clk);
      mStrobe = 1'b0;
      cmp($sformatf("vec%0d strobe one cycle", v), 64'(cmdStrobe), 64'(1'b0));
    end

    buildFrame(LOCAL_MAC, 16'h88B5, 8'h01, 8'h02, 32'h0000_1388, 20, 1'b0);
    applyStimulus(3);
    checkOutput("gapped write");
    cmp("gapped idle_th", 64'(idleTh), 64'(16'd5000));

    buildFrame(LOCAL_MAC, 16'h88B5, 8'h01, 8'h00, 32'h0000_00F1, 20, 1'b0);
    for (int i = 0; i < 10; i++) sendByte(frame[i], 1'b0);
    @(negedge clk);
    rxIf.rx_axis_fifo_tvalid = 1'b0;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async reset mid-frame");
    @(negedge clk);
    reset = 1'b0;
    frame = frame[10:$];
    applyStimulus(0);
    checkOutput("frame remainder after reset");

    for (int n = 0; n < 100; n++) begin
      r = $urandom_range(0, 9);
      rnd64 = {$urandom, $urandom};
      if (r < 5)      dmac = LOCAL_MAC;
      else if (r < 8) dmac = BCAST;
      else if (r == 8) dmac = LOCAL_MAC ^ (48'hFF << (8 * $urandom_range(0, 5)));
      else            dmac = rnd64[47:0];
      etype = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h88B5;
      r = $urandom_range(0, 9);
      op = (r < 8) ? 8'h01 : (r == 8) ? 8'h02 : 8'($urandom);
      len = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 19)) : int'($urandom_range(20, 64));
      buildFrame(dmac, etype, op, 8'($urandom_range(0, 8)), $urandom, len, 1'b1);
      applyStimulus(2);
      checkOutput($sformatf("rand%0d", n));
    end

    @(negedge clk);
    reset = 1'b1;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 65535; k++) begin
      sendByte(8'h00, 1'b1);
      if (mBad != 16'hFFFF) mBad = mBad + 16'd1;
    end
    @(negedge clk);
    rxIf.rx_axis_fifo_tvalid = 1'b0;
    rxIf.rx_axis_fifo_tlast  = 1'b0;
    checkOutput("bad count at max");
    frame.delete();
    frame.push_back(8'h00);
    applyStimulus(0);
    checkOutput("bad count saturated");
    cmp("bad count holds FFFF", 64'(badCount), 64'(16'hFFFF));
    buildFrame(LOCAL_MAC, 16'h88B5, 8'h01, 8'h01, 32'h0000_0042, 20, 1'b0);
    applyStimulus(0);
    checkOutput("write after saturation");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
